match_trigger: RTL

- Sits directly downstream of the correlation match filter and consumes its valid/match pulse pair.
- Qualifies raw correlator hits: requires MIN_HITS matches within a window of WINDOW filter evaluations.
- Stamps each qualified detection with the sample index of its first hit and presents it on a valid/ready event port.
- Applies a post-event holdoff so a single preamble produces exactly one event.

---
 rtl/match_trigger_pkg.sv | 27 ++
 rtl/match_trigger_sat_counter.sv | 23 ++
 rtl/match_trigger.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/match_trigger_pkg.sv
// Shared types, config field positions and reset defaults
// for the correlator hit qualifier.
package match_trigger_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam int CFG_EN_BIT   = 31;
    localparam int CFG_CLR_BIT  = 30;
    localparam int CFG_HOLD_LSB = 16;
    localparam int CFG_HOLD_W   = 12;
    localparam int CFG_WIN_LSB  = 8;
    localparam int CFG_MIN_LSB  = 0;

    localparam logic [7:0]            RST_MIN_HITS = 8'd2;
    localparam logic [7:0]            RST_WINDOW   = 8'd8;
    localparam logic [CFG_HOLD_W-1:0] RST_HOLDOFF  = 12'd64;

    function automatic logic [7:0] eff_min(input logic [7:0] m);
        return (m == 8'd0) ? 8'd1 : m;
    endfunction

endpackage

// File: rtl/match_trigger_sat_counter.sv
// Width-parameterised saturating up-counter with
// synchronous clear taking priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/match_trigger.sv
// Qualifies correlator hits over a window, timestamps the
// first hit and emits one event per detection with holdoff.
module match_trigger
    import match_trigger_pkg::*;
#(
    parameter int TS_WIDTH   = 32,
    parameter int DROP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxstrobe,
    input  logic                  valid,
    input  logic                  match,
    input  logic                  tcwrite,
    input  logic [31:0]           cdata,
    input  logic                  event_ready,
    output logic                  event_valid,
    output logic [TS_WIDTH-1:0]   event_timestamp,
    output logic [7:0]            event_hits,
    output logic                  busy,
    output logic [DROP_WIDTH-1:0] drop_count,
    output logic [15:0]           debugbus
);

    state_t state;
    state_t state_nx;

    logic [TS_WIDTH-1:0]   sample_cnt;
    logic [TS_WIDTH-1:0]   ts;
    logic                  cfg_en;
    logic [7:0]            cfg_min;
    logic [7:0]            cfg_win;
    logic [CFG_HOLD_W-1:0] cfg_hold;
    logic [7:0]            sh_min;
    logic [7:0]            win_cnt;
    logic [7:0]            win_dec;
    logic [CFG_HOLD_W-1:0] hold_cnt;
    logic [7:0]            hits;
    logic [7:0]            hits_upd;
    logic                  hit;
    logic                  start;
    logic                  hits_inc;
    logic                  hits_clr;
    logic                  drop_inc;
    logic                  drop_clr;
    logic                  cfg_unused;

    assign hit        = valid & match;
    assign cfg_unused = ^cdata[29:28];
    assign hits_upd   = (hit && hits != 8'hFF) ? hits + 8'd1 : hits;
    assign win_dec    = (win_cnt == 8'd0) ? 8'd0 : win_cnt - 8'd1;

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        unique case (state)
            IDLE: begin
                if (hit && cfg_en) begin
                    start    = 1'b1;
                    state_nx = (eff_min(cfg_min) == 8'd1) ? REPORT : COLLECT;
                end
            end
            COLLECT: begin
                if (!cfg_en) begin
                    state_nx = IDLE;
                end else if (valid) begin
                    // A qualifying hit beats window expiry on the same evaluation
                    if (hits_upd >= sh_min) begin
                        state_nx = REPORT;
                    end else if (win_dec == 8'd0) begin
                        state_nx = IDLE;
                    end
                end
            end
            REPORT: begin
                if (event_ready) begin
                    state_nx = cfg_en ? HOLDOFF : IDLE;
                end
            end
            HOLDOFF: begin
                if (!cfg_en || hold_cnt == '0) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign hits_inc = start || (state == COLLECT && hit);
    assign hits_clr = (state != IDLE) && (state_nx == IDLE);
    assign drop_inc = hit && (state == REPORT || state == HOLDOFF);
    assign drop_clr = tcwrite && cdata[CFG_CLR_BIT];

    sat_counter #(.W(8)) u_hits (
        .clk   (clk),
        .reset (reset),
        .inc   (hits_inc),
        .clear (hits_clr),
        .count (hits)
    );

    sat_counter #(.W(DROP_WIDTH)) u_drop (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_inc),
        .clear (drop_clr),
        .count (drop_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sample_cnt <= '0;
            cfg_en     <= 1'b0;
            cfg_min    <= RST_MIN_HITS;
            cfg_win    <= RST_WINDOW;
            cfg_hold   <= RST_HOLDOFF;
        end else begin
            state      <= state_nx;
            sample_cnt <= sample_cnt + TS_WIDTH'(rxstrobe);
            if (tcwrite) begin
                cfg_en   <= cdata[CFG_EN_BIT];
                cfg_min  <= cdata[CFG_MIN_LSB +: 8];
                cfg_win  <= cdata[CFG_WIN_LSB +: 8];
                cfg_hold <= cdata[CFG_HOLD_LSB +: CFG_HOLD_W];
            end
        end
    end

    // Shadowed detection parameters; later writes only affect the next detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts       <= '0;
            sh_min   <= '0;
            win_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            if (start) begin
                ts      <= sample_cnt;
                sh_min  <= eff_min(cfg_min);
                win_cnt <= cfg_win;
            end else if (state == COLLECT && valid) begin
                win_cnt <= win_dec;
            end
            if (state != HOLDOFF && state_nx == HOLDOFF) begin
                hold_cnt <= cfg_hold;
            end else if (state == HOLDOFF && rxstrobe && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    assign event_valid     = (state == REPORT);
    assign event_timestamp = ts;
    assign event_hits      = hits;
    assign busy            = (state != IDLE);
    assign debugbus        = {state, hits[5:0], win_cnt};

endmodule
